// File: rtl/hazard_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_if
// Description : Decode-side bundle between the ID stage and hazard_ctrl.
//               Decode drives the register addresses and decodes. The
//               sequencer returns stall, flush, freeze and forwarding selects.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] reg_s_addr;
  logic [REG_AW-1:0] reg_t_addr;
  logic              use_s;
  logic              use_t;
  logic              reg_d_we_id;
  logic [REG_AW-1:0] reg_d_addr_id;
  logic              load_id;
  logic              mem_acc_id;
  logic              branch_id;
  logic              jump;
  logic              mem_ready;

  logic              stall_if;
  logic              stall_id;
  logic              bubble_ex;
  logic              freeze;
  logic              flush_if;
  logic [1:0]        fwd_s_ex;
  logic [1:0]        fwd_t_ex;
  logic              fwd_s_id;
  logic              fwd_t_id;

  // Decode / pipeline side
  modport master (
    output reg_s_addr, reg_t_addr, use_s, use_t, reg_d_we_id, reg_d_addr_id,
           load_id, mem_acc_id, branch_id, jump, mem_ready,
    input  stall_if, stall_id, bubble_ex, freeze, flush_if,
           fwd_s_ex, fwd_t_ex, fwd_s_id, fwd_t_id
  );

  // Sequencer side
  modport slave (
    input  reg_s_addr, reg_t_addr, use_s, use_t, reg_d_we_id, reg_d_addr_id,
           load_id, mem_acc_id, branch_id, jump, mem_ready,
    output stall_if, stall_id, bubble_ex, freeze, flush_if,
           fwd_s_ex, fwd_t_ex, fwd_s_id, fwd_t_id
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline sequencer for the 5-stage core. It shadows the
//               destination registers in flight in EX and MEM. From these it
//               derives load-use and branch stalls, EX/ID forwarding selects,
//               the IF squash after a redirect, and the global freeze while
//               data memory is busy.
//               Optional macro HAZARD_STALL_COUNT_EN adds the stall_cnt
//               output, which counts cycles with stall_if asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_AW = 5
`ifdef HAZARD_STALL_COUNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  hazard_if.slave          hz
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] addr;
    logic              load;
    logic              acc;
  } shadow_t;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // A producer matches a consumer only if it writes a non-zero register that
  // the consumer actually reads. r0 is hard-wired, so it never matches.
  function automatic logic f_match(input shadow_t e,
                                   input logic [REG_AW-1:0] src,
                                   input logic rd);
    return e.we && (e.addr != '0) && (e.addr == src) && rd;
  endfunction

  shadow_t ex_sh;
  shadow_t mem_sh;
  shadow_t id_sh;
  state_t  state;
  state_t  state_nxt;

  logic       m_ex_s, m_ex_t, m_mem_s, m_mem_t;
  logic       haz;
  logic       mem_hold;
  logic [1:0] fwd_s_nxt, fwd_t_nxt;
  logic [1:0] fwd_s_q, fwd_t_q;

  // The WB stage needs no shadow. Forwarding from WB is resolved when the
  // consumer is registered into EX, and at that point the producer sits in
  // MEM. An entry leaving MEM is therefore retired.

  // Decoded ID instruction packed as a shadow entry
  always_comb begin
    id_sh      = '0;
    id_sh.we   = hz.reg_d_we_id;
    id_sh.addr = hz.reg_d_addr_id;
    id_sh.load = hz.load_id;
    id_sh.acc  = hz.mem_acc_id;
  end

  // Hazard detection, FSM next state and control outputs
  always_comb begin
    state_nxt = state;
    m_ex_s    = f_match(ex_sh,  hz.reg_s_addr, hz.use_s);
    m_ex_t    = f_match(ex_sh,  hz.reg_t_addr, hz.use_t);
    m_mem_s   = f_match(mem_sh, hz.reg_s_addr, hz.use_s);
    m_mem_t   = f_match(mem_sh, hz.reg_t_addr, hz.use_t);

    // Load results arrive too late for EX. The branch comparator in ID also
    // cannot take the EX result, nor a load still in MEM.
    haz = (ex_sh.load && (m_ex_s || m_ex_t)) ||
          (hz.branch_id && (m_ex_s || m_ex_t ||
                            (mem_sh.load && (m_mem_s || m_mem_t))));
    mem_hold = mem_sh.acc && !hz.mem_ready;

    unique case (state)
      RUN:      if (mem_hold)     state_nxt = MEM_WAIT;
      MEM_WAIT: if (hz.mem_ready) state_nxt = RUN;
      default:                    state_nxt = RUN;
    endcase

    hz.freeze    = mem_hold;
    hz.stall_if  = mem_hold || haz;
    hz.stall_id  = mem_hold || haz;
    hz.bubble_ex = haz && !mem_hold;
    // A redirect during a stall is squashed once the stall clears, because
    // decode keeps presenting the jump until then.
    hz.flush_if  = hz.jump && !haz && !mem_hold;
    hz.fwd_s_id  = hz.branch_id && m_mem_s && !mem_sh.load;
    hz.fwd_t_id  = hz.branch_id && m_mem_t && !mem_sh.load;
    hz.fwd_s_ex  = fwd_s_q;
    hz.fwd_t_ex  = fwd_t_q;

    // Selects for the instruction about to enter EX. The younger producer
    // (now in EX, moving to MEM) takes priority over the older one.
    fwd_s_nxt = m_ex_s ? 2'b01 : (m_mem_s ? 2'b10 : 2'b00);
    fwd_t_nxt = m_ex_t ? 2'b01 : (m_mem_t ? 2'b10 : 2'b00);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Shadow pipeline and registered EX forwarding selects. All of it holds
  // while memory is busy, and a bubble enters EX on a hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_sh   <= '0;
      mem_sh  <= '0;
      fwd_s_q <= 2'b00;
      fwd_t_q <= 2'b00;
    end else if (!mem_hold) begin
      mem_sh  <= ex_sh;
      ex_sh   <= haz ? '0    : id_sh;
      fwd_s_q <= haz ? 2'b00 : fwd_s_nxt;
      fwd_t_q <= haz ? 2'b00 : fwd_t_nxt;
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  // Stall cycle counter. It wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (rst)              stall_cnt <= '0;
    else if (hz.stall_if) stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. It runs directed
//               scenarios followed by random traffic. All checks are against
//               an in-flight instruction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_if #(.REG_AW(5)) bus ();

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] stall_cnt;
  hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .hz(bus), .stall_cnt(stall_cnt));
`else
  hazard_ctrl #(.REG_AW(5)) dut (.clk(clk), .rst(rst), .hz(bus));
`endif

  // In-flight instruction model: slot 0 = EX, slot 1 = MEM
  typedef struct {
    bit writes;
    int dest;
    bit is_load;
    bit is_mem;
  } instr_t;

  instr_t      pipe [2];
  int          exp_fs, exp_ft;
  bit [31:0]   exp_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Distance to the youngest in-flight writer of src: 1 = EX, 2 = MEM, 0 = none
  function automatic int producer(input int src, input bit rd);
    if (!rd || src == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (pipe[k].writes && pipe[k].dest == src) return k + 1;
    return 0;
  endfunction

  function automatic bit writes_in_mem(input int src, input bit rd);
    return rd && src != 0 && pipe[1].writes && pipe[1].dest == src;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) pipe[k] = '{0, 0, 0, 0};
    exp_fs  = 0;
    exp_ft  = 0;
    exp_cnt = 0;
  endtask

  // One pipeline cycle: drive ID info, check outputs, advance the model
  task automatic cycle(input int s, input int t, input bit us, input bit ut,
                       input bit we, input int d, input bit ld, input bit acc,
                       input bit br, input bit jmp, input bit rdy);
    int  ps, pt;
    bit  haz, hold, stall;
    bit  fs_id, ft_id;
    bus.reg_s_addr    = 5'(s);
    bus.reg_t_addr    = 5'(t);
    bus.use_s         = us;
    bus.use_t         = ut;
    bus.reg_d_we_id   = we;
    bus.reg_d_addr_id = 5'(d);
    bus.load_id       = ld;
    bus.mem_acc_id    = acc;
    bus.branch_id     = br;
    bus.jump          = jmp;
    bus.mem_ready     = rdy;
    #1;
    ps    = producer(s, us);
    pt    = producer(t, ut);
    haz   = ((ps == 1 || pt == 1) && pipe[0].is_load) ||
            (br && (ps == 1 || pt == 1 ||
                    (pipe[1].is_load && (writes_in_mem(s, us) || writes_in_mem(t, ut)))));
    hold  = pipe[1].is_mem && !rdy;
    stall = haz || hold;
    fs_id = br && writes_in_mem(s, us) && !pipe[1].is_load;
    ft_id = br && writes_in_mem(t, ut) && !pipe[1].is_load;

    chk("stall_if",  bus.stall_if,  stall);
    chk("stall_id",  bus.stall_id,  stall);
    chk("bubble_ex", bus.bubble_ex, haz && !hold);
    chk("freeze",    bus.freeze,    hold);
    chk("flush_if",  bus.flush_if,  jmp && !stall);
    chk("fwd_s_ex",  bus.fwd_s_ex,  exp_fs);
    chk("fwd_t_ex",  bus.fwd_t_ex,  exp_ft);
    chk("fwd_s_id",  bus.fwd_s_id,  fs_id);
    chk("fwd_t_id",  bus.fwd_t_id,  ft_id);
`ifdef HAZARD_STALL_COUNT_EN
    chk("stall_cnt", stall_cnt, exp_cnt);
`endif

    if (rst) begin
      model_reset();
    end else begin
      if (stall) exp_cnt = exp_cnt + 1;
      if (!hold) begin
        pipe[1] = pipe[0];
        if (haz) begin
          pipe[0] = '{0, 0, 0, 0};
          exp_fs  = 0;
          exp_ft  = 0;
        end else begin
          pipe[0] = '{we, d, ld, acc};
          exp_fs  = ps;   // distance 1 -> 01 (MEM result), 2 -> 10 (WB result)
          exp_ft  = pt;
        end
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic nop(input bit rdy);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    bus.reg_s_addr = '0; bus.reg_t_addr = '0; bus.use_s = 0; bus.use_t = 0;
    bus.reg_d_we_id = 0; bus.reg_d_addr_id = '0; bus.load_id = 0;
    bus.mem_acc_id = 0; bus.branch_id = 0; bus.jump = 0; bus.mem_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Reset state with idle inputs
    nop(1);

    // Load r5 then add using r5: one stall, then WB forward
    cycle(0, 0, 0, 0, 1, 5, 1, 1, 0, 0, 1);
    cycle(5, 6, 1, 1, 1, 8, 0, 0, 0, 0, 1);
    cycle(5, 6, 1, 1, 1, 8, 0, 0, 0, 0, 1);
    nop(1);

    // ALU r3 then add reading r3 as t: no stall, MEM forward
    cycle(1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 1);
    cycle(4, 3, 1, 1, 1, 9, 0, 0, 0, 0, 1);
    nop(1); nop(1);

    // ALU r7 then beq on r7: one stall, then ID forward
    cycle(1, 2, 1, 1, 1, 7, 0, 0, 0, 0, 1);
    cycle(7, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1);
    cycle(7, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1);
    nop(1); nop(1);

    // Jump without hazard, then jump during a load-use stall
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 9, 1, 1, 0, 0, 1);
    cycle(9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    cycle(9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    nop(1); nop(1);

    // Store reaches MEM with memory busy for 3 cycles
    cycle(2, 4, 1, 1, 0, 0, 0, 1, 0, 0, 1);
    cycle(1, 1, 1, 1, 1, 6, 0, 0, 0, 0, 1);
    nop(0); nop(0); nop(0);
    nop(1); nop(1);

    // r0 is never a hazard or forward source
    cycle(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1);
    cycle(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1);
    nop(1); nop(1);

    // Reset while waiting on memory
    cycle(0, 0, 0, 0, 1, 4, 1, 1, 0, 0, 1);
    nop(1);
    nop(0);
    rst = 1'b1;
    nop(0);
    rst = 1'b0;
    nop(1);

    // Random traffic over a small register set to provoke frequent matches
    for (int n = 0; n < 400; n++) begin
      bit ld, acc;
      ld  = ($urandom_range(0, 3) == 0);
      acc = ld | ($urandom_range(0, 5) == 0);
      cycle($urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom), 1'($urandom),
            ld | 1'($urandom), $urandom_range(0, 7), ld, acc,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
